// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: two requesters (ALU = 0, load = 1) share one
// register-file write port. Ties go round-robin against the last accepted requester.
// The accepted write reaches the register file one cycle later. Writes to register 0
// complete the handshake but are never issued.
module rf_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              last_grant,
  output logic [15:0]       commit_count
);

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [ADDR_W-1:0] acc_reg;
  logic [DATA_W-1:0] acc_data;
  logic              acc_nonzero;

  logic              write_en_q;
  logic [ADDR_W-1:0] write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic              last_grant_q;
  logic [15:0]       commit_count_q;

  // Grant decode: each grant is built from the raw valids and last_grant only, so at
  // most one can be high and neither depends on the other ready output.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst && !hold) begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end
  end

  // Select the winning request's payload.
  always_comb begin
    accept      = grant0 || grant1;
    acc_reg     = grant1 ? req1_reg  : req0_reg;
    acc_data    = grant1 ? req1_data : req0_data;
    acc_nonzero = (acc_reg != '0);
  end

  // Write pipeline and bookkeeping; synchronous active-low reset drops any in-flight
  // pulse and any acceptance presented in the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_en_q     <= 1'b0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
      last_grant_q   <= 1'b1;
      commit_count_q <= 16'd0;
    end else begin
      write_en_q <= 1'b0;
      if (accept) begin
        write_reg_q  <= acc_reg;
        write_data_q <= acc_data;
        last_grant_q <= grant1;
        write_en_q   <= acc_nonzero;
        // Count at the same edge the pulse is launched; wraps naturally at 16 bits.
        if (acc_nonzero) begin
          commit_count_q <= commit_count_q + 16'd1;
        end
      end
    end
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign write_en     = write_en_q;
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign last_grant   = last_grant_q;
  assign commit_count = commit_count_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, random traffic
// against a behavioural model, and a commit counter wrap sequence.
module tb_rf_write_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst;
  logic          hold;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_reg, req1_reg;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          write_en;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          last_grant;
  logic [15:0]   commit_count;

  int checks;
  int failures;

  rf_write_arbiter #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .req0_valid  (req0_valid),
    .req0_reg    (req0_reg),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_reg    (req1_reg),
    .req1_data   (req1_data),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .write_en    (write_en),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .last_grant  (last_grant),
    .commit_count(commit_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic          rst;
    logic          hold;
    logic          v0;
    logic [AW-1:0] r0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] r1;
    logic [DW-1:0] d1;
    logic          e_rdy0;
    logic          e_rdy1;
    logic          e_we;
    logic [AW-1:0] e_reg;
    logic [DW-1:0] e_data;
    logic          e_lg;
    logic [15:0]   e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic h,
                     input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                     input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                     input logic er0, input logic er1, input logic ewe,
                     input logic [AW-1:0] ereg, input logic [DW-1:0] edata,
                     input logic elg, input logic [15:0] ecnt);
    vec_t v;
    v.rst = r; v.hold = h;
    v.v0 = v0; v.r0 = r0; v.d0 = d0;
    v.v1 = v1; v.r1 = r1; v.d1 = d1;
    v.e_rdy0 = er0; v.e_rdy1 = er1; v.e_we = ewe;
    v.e_reg = ereg; v.e_data = edata; v.e_lg = elg; v.e_cnt = ecnt;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic h,
                       input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1);
    rst = r; hold = h;
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
  endtask

  // Behavioural model state
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic        m_lg;
  int unsigned m_cnt;
  logic [1:0]  starve;

  initial begin
    checks = 0;
    failures = 0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);

    // Reset with both requesters valid
    add(0, 0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0, 0, 5'd0, 32'h0, 1, 16'd0);
    add(0, 0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0, 0, 5'd0, 32'h0, 1, 16'd0);
    // Single request from requester 0
    add(1, 0, 1, 5'd3, 32'h0000_1237, 0, 5'd0, 32'h0, 1, 0, 1, 5'd3, 32'h0000_1237, 0, 16'd1);
    add(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd3, 32'h0000_1237, 0, 16'd1);
    // Register 0: handshake only, no write
    add(1, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hDEAD_BEEF, 0, 1, 0, 5'd0, 32'hDEAD_BEEF, 1, 16'd1);
    // Contention: grants alternate 0,1,0,1
    add(1, 0, 1, 5'd5, 32'hCAFE_BABE, 1, 5'd8, 32'hA5A5_A5A5, 1, 0, 1, 5'd5, 32'hCAFE_BABE, 0, 16'd2);
    add(1, 0, 1, 5'd5, 32'hCAFE_BABE, 1, 5'd8, 32'hA5A5_A5A5, 0, 1, 1, 5'd8, 32'hA5A5_A5A5, 1, 16'd3);
    add(1, 0, 1, 5'd5, 32'hCAFE_BABE, 1, 5'd8, 32'hA5A5_A5A5, 1, 0, 1, 5'd5, 32'hCAFE_BABE, 0, 16'd4);
    add(1, 0, 1, 5'd5, 32'hCAFE_BABE, 1, 5'd8, 32'hA5A5_A5A5, 0, 1, 1, 5'd8, 32'hA5A5_A5A5, 1, 16'd5);
    // Hold blocks grants; released request is accepted
    add(1, 1, 1, 5'd10, 32'h0000_00AA, 0, 5'd0, 32'h0, 0, 0, 0, 5'd8, 32'hA5A5_A5A5, 1, 16'd5);
    add(1, 1, 1, 5'd10, 32'h0000_00AA, 0, 5'd0, 32'h0, 0, 0, 0, 5'd8, 32'hA5A5_A5A5, 1, 16'd5);
    add(1, 0, 1, 5'd10, 32'h0000_00AA, 0, 5'd0, 32'h0, 1, 0, 1, 5'd10, 32'h0000_00AA, 0, 16'd6);
    // Hold during the pulse cycle: the pulse already launched, nothing new granted
    add(1, 1, 1, 5'd11, 32'h0000_00BB, 0, 5'd0, 32'h0, 0, 0, 0, 5'd10, 32'h0000_00AA, 0, 16'd6);
    // Accept, then reset at the next edge with a request still presented
    add(1, 0, 1, 5'd7, 32'h0000_0077, 0, 5'd0, 32'h0, 1, 0, 1, 5'd7, 32'h0000_0077, 0, 16'd7);
    add(0, 0, 1, 5'd7, 32'h0000_0077, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 1, 16'd0);
    add(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 1, 16'd0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].hold, tbl[i].v0, tbl[i].r0, tbl[i].d0,
            tbl[i].v1, tbl[i].r1, tbl[i].d1);
      #1;
      chk($sformatf("vec%0d ready0", i), 32'(req0_ready), 32'(tbl[i].e_rdy0));
      chk($sformatf("vec%0d ready1", i), 32'(req1_ready), 32'(tbl[i].e_rdy1));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d write_en", i), 32'(write_en), 32'(tbl[i].e_we));
      chk($sformatf("vec%0d write_reg", i), 32'(write_reg), 32'(tbl[i].e_reg));
      chk($sformatf("vec%0d write_data", i), write_data, tbl[i].e_data);
      chk($sformatf("vec%0d last_grant", i), 32'(last_grant), 32'(tbl[i].e_lg));
      chk($sformatf("vec%0d commit_count", i), 32'(commit_count), 32'(tbl[i].e_cnt));
    end

    // Random traffic against the model; the first cycle is forced into reset to sync.
    m_we = 0; m_reg = 0; m_data = 0; m_lg = 1; m_cnt = 0; starve = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      logic r, h, v0, v1;
      logic [AW-1:0] r0, r1;
      logic [DW-1:0] d0, d1;
      int win;
      r  = (n == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      h  = ($urandom_range(0, 4) == 0);
      v0 = ($urandom_range(0, 9) < 6);
      v1 = ($urandom_range(0, 9) < 6);
      r0 = AW'($urandom_range(0, 3));
      r1 = AW'($urandom_range(0, 3));
      d0 = $urandom;
      d1 = $urandom;
      @(negedge clk);
      drive(r, h, v0, r0, d0, v1, r1, d1);

      // Who should win this cycle, straight from the arbitration rules
      win = -1;
      if (r && !h) begin
        if (v0 && v1) win = m_lg ? 0 : 1;
        else if (v0)  win = 0;
        else if (v1)  win = 1;
      end

      #1;
      chk("rand ready0", 32'(req0_ready), (win == 0) ? 32'd1 : 32'd0);
      chk("rand ready1", 32'(req1_ready), (win == 1) ? 32'd1 : 32'd0);
      chk("rand one_hot", 32'(req0_ready && req1_ready), 32'd0);

      // A previously denied requester, still valid, must win the next open cycle.
      if (r && !h) begin
        for (int k = 0; k < 2; k++) begin
          if (starve[k] && ((k == 0) ? v0 : v1))
            chk("rand no_starve", 32'((k == 0) ? req0_ready : req1_ready), 32'd1);
        end
      end
      if (!r) begin
        starve = 2'b00;
      end else if (!h) begin
        starve[0] = v0 && (win != 0);
        starve[1] = v1 && (win != 1);
      end else begin
        starve[0] = starve[0] && v0;
        starve[1] = starve[1] && v1;
      end

      @(posedge clk);
      if (!r) begin
        m_we = 0; m_reg = 0; m_data = 0; m_lg = 1; m_cnt = 0;
      end else if (win >= 0) begin
        m_reg  = (win == 1) ? r1 : r0;
        m_data = (win == 1) ? d1 : d0;
        m_lg   = (win == 1);
        m_we   = (m_reg != 0);
        if (m_we) m_cnt = (m_cnt + 1) % 65536;
      end else begin
        m_we = 0;
      end
      #1;
      chk("rand write_en", 32'(write_en), 32'(m_we));
      chk("rand write_reg", 32'(write_reg), 32'(m_reg));
      chk("rand write_data", write_data, m_data);
      chk("rand last_grant", 32'(last_grant), 32'(m_lg));
      chk("rand commit_count", 32'(commit_count), m_cnt);
    end

    // Commit counter wrap: 65535 writes reach 0xFFFF, one more wraps to zero.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 5'd1, 32'h1234_5678, 1'b0, '0, '0);
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap count_ffff", 32'(commit_count), 32'h0000_FFFF);
    chk("wrap write_en", 32'(write_en), 32'd1);
    @(posedge clk);
    #1;
    chk("wrap count_zero", 32'(commit_count), 32'h0000_0000);
    chk("wrap write_en_after", 32'(write_en), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register index width (32 registers).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-low (sampled at rising clk; 0 = reset).
REQ-005 The block SHALL have port hold  input  1  when 1, no requester is granted that cycle.
REQ-006 The block SHALL have ports req0_valid, req1_valid  input  1  requester 0 (ALU) and requester 1 (load) write request.
REQ-007 The block SHALL have ports req0_reg, req1_reg  input  ADDR_W  destination register index per requester.
REQ-008 The block SHALL have ports req0_data, req1_data  input  DATA_W  write data per requester.
REQ-009 The block SHALL have ports req0_ready, req1_ready  output  1  grant; the request is accepted when valid and ready are both 1.
REQ-010 The block SHALL have port write_en  output  1  write enable to the register file.
REQ-011 The block SHALL have port write_reg  output  ADDR_W  register file write index.
REQ-012 The block SHALL have port write_data  output  DATA_W  register file write data.
REQ-013 The block SHALL have port last_grant  output  1  index of the requester most recently accepted.
REQ-014 The block SHALL have port commit_count  output  16  number of register file writes issued since reset.

Function
REQ-015 readyN SHALL be combinational: 0 when hold=1 or rst=0; otherwise granted per REQ-016..018.
REQ-016 Only one requester valid: that requester SHALL get ready=1.
REQ-017 Both valid: the requester not equal to last_grant SHALL get ready=1, the other 0 (round-robin).
REQ-018 At most one ready SHALL be 1 in any cycle; ready SHALL NOT depend on readyN of the other port.
REQ-019 On acceptance, write_reg/write_data SHALL register the accepted index/data and last_grant SHALL update to the accepted requester at the same clock edge.
REQ-020 write_en SHALL be 1 for exactly the one cycle after an acceptance whose index is nonzero; latency acceptance to write_en = 1 cycle.
REQ-021 Acceptance with index 0 SHALL complete the handshake but leave write_en=0 and commit_count unchanged.
REQ-022 Cycle without acceptance: write_en SHALL be 0; write_reg/write_data SHALL hold previous values.
REQ-023 commit_count SHALL increment by 1 at each edge where write_en is driven to 1, wrapping 0xFFFF -> 0x0000.
REQ-024 hold asserted while a write_en pulse is in flight SHALL NOT cancel that pulse.
REQ-025 Both requesters targeting the same nonzero index SHALL be serialised per REQ-017; last accepted data wins in the register file.
REQ-026 A valid requester denied a grant SHALL be granted in the next cycle in which hold=0 (no starvation beyond 1 grant).

Reset
REQ-027 With rst=0 at a rising clk edge: write_en=0, write_reg=0, write_data=0, last_grant=1 (so requester 0 wins the first tie), commit_count=0.
REQ-028 Reset mid-operation SHALL drop any acceptance in the same cycle and any pending write_en pulse; no write issued after reset without a new acceptance.
REQ-029 No state SHALL change asynchronously; rst deasserting between edges has no effect until the next edge.

Verification
REQ-030 Reset: rst=0 for 2 edges with both valid -> ready0=ready1=0, write_en=0, commit_count=0, last_grant=1.
REQ-031 Single: req0 valid reg=3 data=0x0000_1237 one cycle -> ready0=1; next cycle write_en=1, write_reg=3, write_data=0x0000_1237; commit_count=1.
REQ-032 Contention: both valid for 4 cycles (req0 reg=5 data=0xCAFE_BABE, req1 reg=8 data=0xA5A5_A5A5) -> grants alternate 0,1,0,1; write_en high 4 consecutive cycles; commit_count +4.
REQ-033 Register 0: req1 valid reg=0 data=0xDEAD_BEEF -> ready1=1, next cycle write_en=0, commit_count unchanged, last_grant=1.
REQ-034 Hold: hold=1 with req0 valid reg=10 -> ready0=0, write_en=0 while held; hold dropped -> accept, write_en pulse one cycle later.
REQ-035 Reset mid-flight: accept req0 reg=7, rst=0 at next edge -> write_en=0 that cycle and after, commit_count=0.
